// File: rtl/dbg_mem_arbiter.sv
// ---------------------------------------------------------------------------
// dbg_mem_arbiter
// Shares the single data-memory port between the CPU load/store unit and the
// debug controller. Debug requests are one-cycle pulses whose operands are
// latched on capture. CPU and debug traffic are granted round-robin. Debug
// transfers abort after TIMEOUT cycles without mem_ack.
//
// Optional build macro: DBG_MEM_ALIGN_CHECK_EN
//   defined   : misaligned debug word accesses abort with o_dbg_err=1 and do
//               not touch memory
//   undefined : misaligned debug word accesses are aligned down (addr[1:0]=0)
//
// Ports
//   clk, rst_n                 clock / asynchronous active-low reset
//   i_dbg_req/we/byte/addr/wdata   debug request pulse and operands
//   o_dbg_busy/done/err/rdata      debug status and completion
//   i_cpu_req/we/be/addr/wdata     CPU level request, held until o_cpu_done
//   o_cpu_rdata/done/stall         CPU completion and stall
//   o_mem_req/we/be/addr/wdata     memory request, held until i_mem_ack
//   i_mem_rdata, i_mem_ack         memory response
// ---------------------------------------------------------------------------
module dbg_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic              i_dbg_byte,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [31:0]       i_dbg_wdata,
    output logic              o_dbg_busy,
    output logic              o_dbg_done,
    output logic              o_dbg_err,
    output logic [31:0]       o_dbg_rdata,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [3:0]        i_cpu_be,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [31:0]       i_cpu_wdata,
    output logic [31:0]       o_cpu_rdata,
    output logic              o_cpu_done,
    output logic              o_cpu_stall,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    input  logic              i_mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU_XFER,
        ST_DBG_XFER,
        ST_DBG_DONE
    } state_t;

    // Last counter value before expiry: the TIMEOUT-th ack-less cycle aborts.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t              r_state, w_state_next;
    logic                r_last_dbg, w_last_dbg_next;   // 1: debug had the last grant
    logic [15:0]         r_cnt, w_cnt_next;
    logic                r_dbg_pend, w_dbg_pend_next;
    logic                r_dbg_busy, w_dbg_busy_next;
    logic                r_dbg_we, w_dbg_we_next;
    logic                r_dbg_byte, w_dbg_byte_next;
    logic [ADDR_W-1:0]   r_dbg_addr, w_dbg_addr_next;
    logic [31:0]         r_dbg_wdata, w_dbg_wdata_next;
    logic                r_dbg_err, w_dbg_err_next;
    logic [31:0]         r_dbg_rdata, w_dbg_rdata_next;
    logic                r_skip, w_skip_next;           // abort without memory: keep last grant
    logic                r_mem_req, w_mem_req_next;
    logic                r_mem_we, w_mem_we_next;
    logic [3:0]          r_mem_be, w_mem_be_next;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_next;
    logic [31:0]         r_mem_wdata, w_mem_wdata_next;

    logic                w_dbg_grant;
    logic                w_cpu_grant;
    logic                w_cpu_done;
    logic [7:0]          w_rd_byte;

    // Tie goes to whoever did not have the last grant.
    assign w_dbg_grant = r_dbg_pend & (~i_cpu_req | ~r_last_dbg);
    assign w_cpu_grant = i_cpu_req & ~w_dbg_grant;
    assign w_cpu_done  = (r_state == ST_CPU_XFER) & i_mem_ack;

    always_comb begin
        w_rd_byte = i_mem_rdata[7:0];
        case (r_dbg_addr[1:0])
            2'd1:    w_rd_byte = i_mem_rdata[15:8];
            2'd2:    w_rd_byte = i_mem_rdata[23:16];
            2'd3:    w_rd_byte = i_mem_rdata[31:24];
            default: w_rd_byte = i_mem_rdata[7:0];
        endcase
    end

    always_comb begin
        w_state_next     = r_state;
        w_last_dbg_next  = r_last_dbg;
        w_cnt_next       = r_cnt;
        w_dbg_pend_next  = r_dbg_pend;
        w_dbg_busy_next  = r_dbg_busy;
        w_dbg_we_next    = r_dbg_we;
        w_dbg_byte_next  = r_dbg_byte;
        w_dbg_addr_next  = r_dbg_addr;
        w_dbg_wdata_next = r_dbg_wdata;
        w_dbg_err_next   = r_dbg_err;
        w_dbg_rdata_next = r_dbg_rdata;
        w_skip_next      = r_skip;
        w_mem_req_next   = r_mem_req;
        w_mem_we_next    = r_mem_we;
        w_mem_be_next    = r_mem_be;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;

        // Requests arriving while busy are dropped.
        if (i_dbg_req && !r_dbg_busy) begin
            w_dbg_busy_next  = 1'b1;
            w_dbg_pend_next  = 1'b1;
            w_dbg_we_next    = i_dbg_we;
            w_dbg_byte_next  = i_dbg_byte;
            w_dbg_addr_next  = i_dbg_addr;
            w_dbg_wdata_next = i_dbg_wdata;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_dbg_grant) begin
                    w_dbg_pend_next = 1'b0;
                    w_mem_we_next   = r_dbg_we;
                    if (r_dbg_byte) begin
                        w_mem_be_next    = 4'b0001 << r_dbg_addr[1:0];
                        w_mem_addr_next  = r_dbg_addr;
                        w_mem_wdata_next = {4{r_dbg_wdata[7:0]}};
                    end else begin
                        w_mem_be_next    = 4'hF;
                        w_mem_addr_next  = {r_dbg_addr[ADDR_W-1:2], 2'b00};
                        w_mem_wdata_next = r_dbg_wdata;
                    end
`ifdef DBG_MEM_ALIGN_CHECK_EN
                    if (!r_dbg_byte && (r_dbg_addr[1:0] != 2'b00)) begin
                        w_skip_next      = 1'b1;
                        w_dbg_err_next   = 1'b1;
                        w_dbg_rdata_next = 32'h0;
                        w_state_next     = ST_DBG_DONE;
                    end else begin
                        w_skip_next    = 1'b0;
                        w_mem_req_next = 1'b1;
                        w_state_next   = ST_DBG_XFER;
                    end
`else
                    w_skip_next    = 1'b0;
                    w_mem_req_next = 1'b1;
                    w_state_next   = ST_DBG_XFER;
`endif
                end else if (w_cpu_grant) begin
                    w_mem_req_next   = 1'b1;
                    w_mem_we_next    = i_cpu_we;
                    w_mem_be_next    = i_cpu_be;
                    w_mem_addr_next  = i_cpu_addr;
                    w_mem_wdata_next = i_cpu_wdata;
                    w_state_next     = ST_CPU_XFER;
                end
            end
            ST_CPU_XFER: begin
                if (i_mem_ack) begin
                    w_mem_req_next  = 1'b0;
                    w_last_dbg_next = 1'b0;
                    w_state_next    = ST_IDLE;
                end
            end
            ST_DBG_XFER: begin
                // An ack in the expiry cycle still wins.
                if (i_mem_ack) begin
                    w_mem_req_next   = 1'b0;
                    w_dbg_err_next   = 1'b0;
                    w_dbg_rdata_next = r_dbg_byte ? {24'h0, w_rd_byte} : i_mem_rdata;
                    w_state_next     = ST_DBG_DONE;
                end else if (r_cnt == TO_LAST) begin
                    w_mem_req_next   = 1'b0;
                    w_dbg_err_next   = 1'b1;
                    w_dbg_rdata_next = 32'h0;
                    w_state_next     = ST_DBG_DONE;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            ST_DBG_DONE: begin
                w_dbg_busy_next = 1'b0;
                w_cnt_next      = 16'd0;
                if (!r_skip) begin
                    w_last_dbg_next = 1'b1;
                end
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last_dbg  <= 1'b1;
            r_cnt       <= 16'd0;
            r_dbg_pend  <= 1'b0;
            r_dbg_busy  <= 1'b0;
            r_dbg_we    <= 1'b0;
            r_dbg_byte  <= 1'b0;
            r_dbg_addr  <= '0;
            r_dbg_wdata <= 32'h0;
            r_dbg_err   <= 1'b0;
            r_dbg_rdata <= 32'h0;
            r_skip      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'h0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
        end else begin
            r_state     <= w_state_next;
            r_last_dbg  <= w_last_dbg_next;
            r_cnt       <= w_cnt_next;
            r_dbg_pend  <= w_dbg_pend_next;
            r_dbg_busy  <= w_dbg_busy_next;
            r_dbg_we    <= w_dbg_we_next;
            r_dbg_byte  <= w_dbg_byte_next;
            r_dbg_addr  <= w_dbg_addr_next;
            r_dbg_wdata <= w_dbg_wdata_next;
            r_dbg_err   <= w_dbg_err_next;
            r_dbg_rdata <= w_dbg_rdata_next;
            r_skip      <= w_skip_next;
            r_mem_req   <= w_mem_req_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_be    <= w_mem_be_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
        end
    end

    assign o_dbg_busy  = r_dbg_busy;
    assign o_dbg_done  = (r_state == ST_DBG_DONE);
    assign o_dbg_err   = r_dbg_err;
    assign o_dbg_rdata = r_dbg_rdata;
    assign o_cpu_done  = w_cpu_done;
    assign o_cpu_rdata = w_cpu_done ? i_mem_rdata : 32'h0;
    assign o_cpu_stall = i_cpu_req & ~w_cpu_done;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_be    = r_mem_be;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: doc/dbg_mem_arbiter.md
Name: dbg_mem_arbiter

Overview:
- Shares the MCU's single data-memory port between the CPU load/store unit and the debug controller's memory read/write commands.
- Debug requests are accepted as one-cycle pulses with latched operands.
- CPU and debug traffic are granted round-robin. Debug transactions are bounded by a timeout.
- Sits between the debug controller FSM, the MCU core and the data memory. It replaces the direct core-to-memory connection.

Parameters:
- TIMEOUT, 255, max cycles a debug transfer waits for mem_ack before aborting (1..65535).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- dbg_req  in  1  one-cycle pulse: debug access request
- dbg_we  in  1  1=write, 0=read; sampled with dbg_req
- dbg_byte  in  1  1=byte access, 0=word; sampled with dbg_req
- dbg_addr  in  ADDR_W  byte address; sampled with dbg_req
- dbg_wdata  in  32  write data (byte in [7:0] when dbg_byte); sampled with dbg_req
- dbg_busy  out  1  debug request pending or in flight
- dbg_done  out  1  one-cycle completion pulse
- dbg_err  out  1  valid with dbg_done: timeout or misaligned abort
- dbg_rdata  out  32  read data, valid with dbg_done; byte reads zero-extended
- cpu_req  in  1  CPU access request, level, held until cpu_done
- cpu_we  in  1  CPU write
- cpu_be  in  4  CPU byte enables
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  CPU read data, valid with cpu_done
- cpu_done  out  1  one-cycle CPU completion pulse
- cpu_stall  out  1  cpu_req high and cpu_done low
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_be  out  4  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory

Behaviour:
- Reset, async on rst_n low: all outputs 0, state IDLE, pending cleared, last_grant=DBG (so CPU wins first tie), timeout counter 0. Reset mid-transfer drops the transfer with no done pulse.
- Debug capture:
  - dbg_req while dbg_busy=0 latches operands; dbg_busy=1 from the next cycle.
  - dbg_req while dbg_busy=1 is ignored.
  - dbg_busy falls in the cycle after dbg_done.
- States:
  - IDLE:
    - If CPU and debug are both pending, grant the one not in last_grant.
    - Otherwise grant whichever is pending.
    - A grant registers mem_* and moves to CPU_XFER or DBG_XFER; mem_req is high the next cycle.
  - CPU_XFER:
    - mem_* mirror the latched CPU fields.
    - On mem_ack: cpu_done=1 and cpu_rdata=mem_rdata for one cycle, last_grant=CPU, go to IDLE.
  - DBG_XFER:
    - Counter increments each cycle mem_ack=0.
    - On mem_ack: dbg_rdata is formed, dbg_err=0, go to DBG_DONE.
    - If counter reaches TIMEOUT without ack: mem_req drops, dbg_err=1, dbg_rdata=0, go to DBG_DONE.
  - DBG_DONE: dbg_done=1 for one cycle, last_grant=DBG, counter cleared, go to IDLE.
- mem_ack in the same cycle as timeout expiry counts as success.
- Byte access:
  - mem_be = 4'b0001 << addr[1:0].
  - mem_wdata = the byte replicated 4 times.
  - dbg_rdata = {24'b0, selected byte}.
- Word access: mem_be=4'hF.
- mem_ack outside CPU_XFER/DBG_XFER is ignored.
- Minimum latency:
  - Debug: dbg_req to dbg_done is 4 cycles with zero-wait memory (capture, grant, ack, done).
  - CPU: cpu_req to cpu_done is 2 cycles.

Optional Feature:
- Macro: DBG_MEM_ALIGN_CHECK_EN.
- Defined:
  - A debug word access with addr[1:0]!=0 skips the memory; IDLE goes directly to DBG_DONE with dbg_err=1 and dbg_rdata=0.
  - last_grant is unchanged.
- Undefined: addr[1:0] is forced to 0 for word accesses and the access proceeds normally.

Test Plan:
- Debug word read addr 0x100, memory returns 0xDEADBEEF after 2 wait cycles -> mem_be=F, dbg_done with dbg_rdata=0xDEADBEEF, dbg_err=0, total 6 cycles.
- Debug byte write addr 0x203, data 0x5A -> mem_be=4'b1000, mem_wdata=0x5A5A5A5A; byte read of 0x203 with mem_rdata=0x11223344 -> dbg_rdata=0x00000011.
- cpu_req held continuously plus dbg_req pulse -> grants alternate CPU, DBG, CPU; cpu_stall high while not granted; no starvation.
- Memory never acks a debug read, TIMEOUT=8 -> mem_req drops after 8 cycles, dbg_done with dbg_err=1 and dbg_rdata=0; a following CPU access completes.
- rst_n low during DBG_XFER -> all outputs 0 immediately, no dbg_done; new dbg_req after release completes normally.
- Macro defined, word read addr 0x102 -> dbg_err=1 within 3 cycles, mem_req never asserted; macro undefined -> mem_addr=0x100.
